// File: rtl/bus_rr_arbiter_pkg.sv
// Shared types and helpers for the shared-bus arbiter: FSM states, arbitration
// modes and the destination-decode function.
package bus_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DELIVER} state_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int MAX_PORTS = 16;
  localparam int MAX_ID_W  = 32;

  typedef struct packed {
    logic                 invalid;
    logic [MAX_PORTS-1:0] mask;
  } dest_res_t;

  // Broadcast reaches every port but the source; unicast may not loop back.
  function automatic dest_res_t dest_mask(input logic [MAX_ID_W-1:0] dest,
                                          input logic [3:0]          src,
                                          input int                  drvrs,
                                          input logic [MAX_ID_W-1:0] bcast);
    dest_res_t r;
    r.invalid = 1'b0;
    r.mask    = '0;
    if (dest == bcast) begin
      for (int i = 0; i < MAX_PORTS; i++)
        r.mask[i] = (i < drvrs) && (i != int'(src));
    end else if ((dest < 32'(drvrs)) && (dest != 32'(src))) begin
      r.mask[dest[3:0]] = 1'b1;
    end else begin
      r.invalid = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Source-FIFO / destination-FIFO bundle seen by the arbiter.
interface bus_rr_arbiter_if #(
  parameter int DRVRS   = 4,
  parameter int PCKG_SZ = 16
);
  logic [DRVRS-1:0]              pndng;
  logic [DRVRS-1:0][PCKG_SZ-1:0] D_pop;
  logic [DRVRS-1:0]              pop;
  logic [DRVRS-1:0]              full;
  logic [DRVRS-1:0]              push;
  logic [PCKG_SZ-1:0]            D_push;

  modport master (input pndng, D_pop, full, output pop, push, D_push);
  modport slave  (output pndng, D_pop, full, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_arbiter_prio.sv
// Combinational request picker: rotating priority from ptr, or lowest index
// first when fixed is set.
module rr_prio_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             fixed,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    int   j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = fixed ? k : (int'(ptr) + k) % N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
    any = found;
  end
endmodule

// File: rtl/bus_rr_arbiter.sv
// Shared-bus arbiter: grants one source packet at a time, decodes its
// destination and pushes it to all targets at once, dropping bad IDs.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int               DRVRS     = 4,
  parameter int               PCKG_SZ   = 16,
  parameter int               ID_W      = 8,
  parameter logic [ID_W-1:0]  BROADCAST = {ID_W{1'b1}},
  parameter int               MODE      = 0,
  parameter int               CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_rr_arbiter_if.master      bus,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  busy
);
  localparam int IDX_W = (DRVRS > 1) ? $clog2(DRVRS) : 1;

  state_t             state;
  logic [IDX_W-1:0]   ptr, gnt_idx, arb_idx, nxt_ptr;
  logic [DRVRS-1:0]   gnt_oh, arb_gnt, target;
  logic [PCKG_SZ-1:0] pkt_q, head;
  logic               arb_any, deliver_ok, drop_pkt, take;
  dest_res_t          dres;

  rr_prio_arbiter #(.N(DRVRS), .IDX_W(IDX_W)) u_arb (
    .req   (bus.pndng),
    .ptr   (ptr),
    .fixed (MODE == ARB_FIXED),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign head       = bus.D_pop[gnt_idx];
  assign dres       = dest_mask(32'(head[PCKG_SZ-1 -: ID_W]), 4'(gnt_idx), DRVRS, 32'(BROADCAST));
  assign drop_pkt   = dres.invalid || (dres.mask == '0);
  assign deliver_ok = ((target & bus.full) == '0);
  assign nxt_ptr    = ((MODE == ARB_FIXED) || (int'(arb_idx) == DRVRS - 1)) ? '0 : arb_idx + 1'b1;

  // Arbitration edges: idle, end of a dropped grant, end of a completed delivery.
  assign take = arb_any && ((state == ST_IDLE) ||
                            (state == ST_GRANT && drop_pkt) ||
                            (state == ST_DELIVER && deliver_ok));

  assign bus.pop    = (state == ST_GRANT) ? gnt_oh : '0;
  assign bus.push   = (state == ST_DELIVER && deliver_ok) ? target : '0;
  assign bus.D_push = (state == ST_DELIVER && deliver_ok) ? pkt_q : '0;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      gnt_idx  <= '0;
      gnt_oh   <= '0;
      target   <= '0;
      pkt_q    <= '0;
      drop_cnt <= '0;
    end else begin
      if (take) begin
        gnt_idx <= arb_idx;
        gnt_oh  <= arb_gnt;
        ptr     <= nxt_ptr;
      end
      case (state)
        ST_IDLE: if (arb_any) state <= ST_GRANT;
        ST_GRANT: begin
          pkt_q  <= head;
          target <= dres.mask[DRVRS-1:0];
          if (drop_pkt) begin
            if (drop_cnt != {CNT_W{1'b1}}) drop_cnt <= drop_cnt + 1'b1;
            state <= arb_any ? ST_GRANT : ST_IDLE;
          end else begin
            state <= ST_DELIVER;
          end
        end
        // Broadcasts wait until every target has room; never partial.
        ST_DELIVER: if (deliver_ok) state <= arb_any ? ST_GRANT : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
